// File: rtl/flash_cmd_pkg.sv
// Shared opcode constants, parser state encoding and opcode classification
// helpers for the SPI flash command assembler.
package flash_cmd_pkg;

    localparam logic [7:0] OP_WREN         = 8'h06;
    localparam logic [7:0] OP_RDSR         = 8'h05;
    localparam logic [7:0] OP_READ         = 8'h03;
    localparam logic [7:0] OP_SECTOR_ERASE = 8'h20;
    localparam logic [7:0] OP_PROGRAM      = 8'h02;

    typedef enum logic [2:0] {
        ST_OPCODE,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } state_t;

    function automatic logic op_has_addr(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_SECTOR_ERASE) || (op == OP_PROGRAM);
    endfunction

    function automatic logic op_has_data(input logic [7:0] op);
        return (op == OP_PROGRAM);
    endfunction

    function automatic logic op_supported(input logic [7:0] op);
        return op_has_addr(op) || (op == OP_WREN) || (op == OP_RDSR);
    endfunction

endpackage

// File: rtl/nibble_byte_packer.sv
// Detects rising edges of the receive-stage nibble strobe and pairs nibbles
// into bytes, high nibble first. The completed byte is presented combinationally.
module nibble_byte_packer
    import flash_cmd_pkg::*;
(
    input  logic       i_sck,
    input  logic       i_ss,
    input  logic       i_nib_valid,
    input  logic [3:0] i_nib,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data
);

    logic       r_prev_valid;
    logic       r_have_hi;
    logic [3:0] r_hi;
    logic       w_edge;

    assign w_edge       = i_nib_valid & ~r_prev_valid;
    assign o_byte_valid = w_edge & r_have_hi;
    assign o_byte_data  = {r_hi, i_nib};

    always_ff @(posedge i_sck) begin
        if (i_ss) begin
            r_prev_valid <= 1'b0;
            r_have_hi    <= 1'b0;
            r_hi         <= 4'h0;
        end else begin
            r_prev_valid <= i_nib_valid;
            if (w_edge) begin
                if (r_have_hi) begin
                    r_have_hi <= 1'b0;
                end else begin
                    r_hi      <= i_nib;
                    r_have_hi <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flash_cmd_assembler.sv
// Parses one chip-select transaction of bytes into a flash command header
// (opcode, optional address) followed by optional program-data bytes.
module flash_cmd_assembler
    import flash_cmd_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int MAX_WR     = 256
) (
    input  logic                    i_sck,
    input  logic                    i_ss,
    input  logic                    i_nib_valid,
    input  logic [3:0]              i_nib,
    output logic                    o_rx_ready,
    output logic                    o_rx_done,
    output logic                    o_cmd_valid,
    output logic [7:0]              o_cmd_op,
    output logic [8*ADDR_BYTES-1:0] o_cmd_addr,
    output logic                    o_wr_valid,
    output logic [7:0]              o_wr_data,
    output logic [8:0]              o_wr_count,
    output logic                    o_err
);

    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int IDX_W  = $clog2(ADDR_BYTES + 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_addr_idx;
    logic                r_cmd_valid;
    logic [7:0]          r_cmd_op;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic                r_wr_valid;
    logic [7:0]          r_wr_data;
    logic [8:0]          r_wr_count;
    logic                r_err;

    logic                w_byte_valid;
    logic [7:0]          w_byte_data;

    nibble_byte_packer u_packer (
        .i_sck        (i_sck),
        .i_ss         (i_ss),
        .i_nib_valid  (i_nib_valid),
        .i_nib        (i_nib),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data)
    );

    // Terminal states ignore further bytes; only a deselect restarts parsing.
    always_ff @(posedge i_sck) begin
        if (i_ss) begin
            r_state     <= ST_OPCODE;
            r_addr_idx  <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= 8'h00;
            r_cmd_addr  <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_data   <= 8'h00;
            r_wr_count  <= 9'd0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_wr_valid  <= 1'b0;
            case (r_state)
                ST_OPCODE: begin
                    if (w_byte_valid) begin
                        r_cmd_op <= w_byte_data;
                        if (!op_supported(w_byte_data)) begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if (op_has_addr(w_byte_data)) begin
                            r_addr_idx <= '0;
                            r_state    <= ST_ADDR;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_byte_valid) begin
                        r_cmd_addr <= (r_cmd_addr << 8) | ADDR_W'(w_byte_data);
                        if (r_addr_idx == IDX_W'(ADDR_BYTES - 1)) begin
                            r_cmd_valid <= 1'b1;
                            r_state     <= op_has_data(r_cmd_op) ? ST_DATA : ST_DONE;
                        end else begin
                            r_addr_idx <= r_addr_idx + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_valid) begin
                        r_wr_data  <= w_byte_data;
                        r_wr_valid <= 1'b1;
                        r_wr_count <= r_wr_count + 9'd1;
                        if (r_wr_count == 9'(MAX_WR - 1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                end
                default: begin
                    r_state <= ST_ERROR;
                end
            endcase
        end
    end

    assign o_rx_ready  = (r_state == ST_OPCODE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign o_rx_done   = (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_op    = r_cmd_op;
    assign o_cmd_addr  = r_cmd_addr;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_data   = r_wr_data;
    assign o_wr_count  = r_wr_count;
    assign o_err       = r_err;

endmodule

// File: tb/tb_flash_cmd_assembler.sv
// Drives directed nibble transactions into two assembler builds (default and
// MAX_WR=2) and checks them every cycle against a byte-list command model.
module tb_flash_cmd_assembler;

    localparam int AB    = 3;
    localparam int MAXWR = 2;

    logic sck = 1'b0;
    logic ss = 1'b0;
    logic nibValid = 1'b0;
    logic [3:0] nib = 4'h0;

    logic d0RxReady, d0RxDone, d0CmdValid, d0WrValid, d0Err;
    logic [7:0] d0CmdOp, d0WrData;
    logic [23:0] d0CmdAddr;
    logic [8:0] d0WrCount;
    logic d1RxReady, d1RxDone, d1CmdValid, d1WrValid, d1Err;
    logic [7:0] d1CmdOp, d1WrData;
    logic [23:0] d1CmdAddr;
    logic [8:0] d1WrCount;

    int checks = 0;
    int failures = 0;
    int cmdPulses0 = 0;
    int wrPulses0 = 0;
    int wrPulses1 = 0;

    flash_cmd_assembler #(.ADDR_BYTES(AB), .MAX_WR(256)) dut0 (
        .i_sck(sck), .i_ss(ss), .i_nib_valid(nibValid), .i_nib(nib),
        .o_rx_ready(d0RxReady), .o_rx_done(d0RxDone), .o_cmd_valid(d0CmdValid),
        .o_cmd_op(d0CmdOp), .o_cmd_addr(d0CmdAddr), .o_wr_valid(d0WrValid),
        .o_wr_data(d0WrData), .o_wr_count(d0WrCount), .o_err(d0Err)
    );

    flash_cmd_assembler #(.ADDR_BYTES(AB), .MAX_WR(MAXWR)) dut1 (
        .i_sck(sck), .i_ss(ss), .i_nib_valid(nibValid), .i_nib(nib),
        .o_rx_ready(d1RxReady), .o_rx_done(d1RxDone), .o_cmd_valid(d1CmdValid),
        .o_cmd_op(d1CmdOp), .o_cmd_addr(d1CmdAddr), .o_wr_valid(d1WrValid),
        .o_wr_data(d1WrData), .o_wr_count(d1WrCount), .o_err(d1Err)
    );

    always #5 sck = ~sck;

    // Model state: the list of bytes seen this transaction, per build
    bit          checkEn = 1'b0;
    bit          mPrev[2];
    bit          mHaveHi[2];
    logic [3:0]  mHi[2];
    logic [7:0]  mBytes[2][0:299];
    int          mN[2];
    bit          eCmdValid[2];
    bit          eWrValid[2];
    bit          eErr[2];
    logic [7:0]  eOp[2];
    logic [23:0] eAddr[2];
    logic [7:0]  eWrData[2];
    int          eWrCount[2];

    function automatic int maxWrOf(input int k);
        return (k == 0) ? 256 : MAXWR;
    endfunction

    function automatic bit isSupported(input logic [7:0] op);
        return op == 8'h06 || op == 8'h05 || op == 8'h03 || op == 8'h20 || op == 8'h02;
    endfunction

    function automatic bit isTerminal(input int k);
        logic [7:0] op;
        if (mN[k] == 0) return 1'b0;
        op = mBytes[k][0];
        if (!isSupported(op) || op == 8'h06 || op == 8'h05) return 1'b1;
        if (op != 8'h02) return mN[k] >= 1 + AB;
        return mN[k] >= 1 + AB + maxWrOf(k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge sck) begin
        for (int k = 0; k < 2; k++) begin
            if (ss) begin
                checkEn = 1'b1;
                mPrev[k] = 1'b0; mHaveHi[k] = 1'b0; mHi[k] = 4'h0; mN[k] = 0;
                eCmdValid[k] = 1'b0; eWrValid[k] = 1'b0; eErr[k] = 1'b0;
                eOp[k] = 8'h00; eAddr[k] = 24'h0; eWrData[k] = 8'h00; eWrCount[k] = 0;
            end else begin
                bit edgeSeen;
                edgeSeen = nibValid && !mPrev[k];
                mPrev[k] = nibValid;
                eCmdValid[k] = 1'b0;
                eWrValid[k] = 1'b0;
                if (edgeSeen && !isTerminal(k)) begin
                    if (!mHaveHi[k]) begin
                        mHi[k] = nib;
                        mHaveHi[k] = 1'b1;
                    end else begin
                        logic [7:0] b;
                        int n;
                        mHaveHi[k] = 1'b0;
                        b = {mHi[k], nib};
                        mBytes[k][mN[k]] = b;
                        mN[k]++;
                        n = mN[k];
                        if (n == 1) begin
                            eOp[k] = b;
                            if (!isSupported(b)) eErr[k] = 1'b1;
                            else if (b == 8'h06 || b == 8'h05) eCmdValid[k] = 1'b1;
                        end else if (n <= 1 + AB) begin
                            eAddr[k] = 24'h0;
                            for (int i = 1; i < n; i++) eAddr[k] = eAddr[k] * 256 + 24'(mBytes[k][i]);
                            if (n == 1 + AB) eCmdValid[k] = 1'b1;
                        end else begin
                            eWrValid[k] = 1'b1;
                            eWrData[k] = b;
                            eWrCount[k] = n - 1 - AB;
                        end
                    end
                end
            end
        end
    end

    always @(negedge sck) begin
        if (checkEn) begin
            checkOutput("d0.rx_ready", 32'(d0RxReady), 32'(!isTerminal(0)));
            checkOutput("d0.rx_done", 32'(d0RxDone), 32'(isTerminal(0)));
            checkOutput("d0.cmd_valid", 32'(d0CmdValid), 32'(eCmdValid[0]));
            checkOutput("d0.cmd_op", 32'(d0CmdOp), 32'(eOp[0]));
            checkOutput("d0.cmd_addr", 32'(d0CmdAddr), 32'(eAddr[0]));
            checkOutput("d0.wr_valid", 32'(d0WrValid), 32'(eWrValid[0]));
            checkOutput("d0.wr_data", 32'(d0WrData), 32'(eWrData[0]));
            checkOutput("d0.wr_count", 32'(d0WrCount), 32'(eWrCount[0]));
            checkOutput("d0.err", 32'(d0Err), 32'(eErr[0]));
            checkOutput("d1.rx_ready", 32'(d1RxReady), 32'(!isTerminal(1)));
            checkOutput("d1.rx_done", 32'(d1RxDone), 32'(isTerminal(1)));
            checkOutput("d1.cmd_valid", 32'(d1CmdValid), 32'(eCmdValid[1]));
            checkOutput("d1.cmd_op", 32'(d1CmdOp), 32'(eOp[1]));
            checkOutput("d1.cmd_addr", 32'(d1CmdAddr), 32'(eAddr[1]));
            checkOutput("d1.wr_valid", 32'(d1WrValid), 32'(eWrValid[1]));
            checkOutput("d1.wr_data", 32'(d1WrData), 32'(eWrData[1]));
            checkOutput("d1.wr_count", 32'(d1WrCount), 32'(eWrCount[1]));
            checkOutput("d1.err", 32'(d1Err), 32'(eErr[1]));
        end
    end

    always @(negedge sck) begin
        if (ss) begin
            cmdPulses0 = 0;
            wrPulses0 = 0;
            wrPulses1 = 0;
        end else begin
            if (d0CmdValid) cmdPulses0++;
            if (d0WrValid) wrPulses0++;
            if (d1WrValid) wrPulses1++;
        end
    end

    task automatic applyStimulus(input logic [3:0] value, input int hold);
        @(negedge sck);
        nibValid = 1'b1;
        nib = value;
        repeat (hold) @(negedge sck);
        nibValid = 1'b0;
        @(negedge sck);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(b[7:4], 1);
        applyStimulus(b[3:0], 1);
    endtask

    task automatic doReset();
        @(negedge sck);
        ss = 1'b1;
        nibValid = 1'b0;
        repeat (2) @(negedge sck);
        ss = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge sck);
    endtask

    initial begin
        doReset();
        settle();
        checkOutput("reset.rx_ready", 32'(d0RxReady), 32'd1);
        checkOutput("reset.rx_done", 32'(d0RxDone), 32'd0);
        checkOutput("reset.cmd_op", 32'(d0CmdOp), 32'd0);
        checkOutput("reset.wr_count", 32'(d0WrCount), 32'd0);

        sendByte(8'h06);
        settle();
        checkOutput("wren.pulses", 32'(cmdPulses0), 32'd1);
        checkOutput("wren.cmd_op", 32'(d0CmdOp), 32'h06);
        checkOutput("wren.rx_done", 32'(d0RxDone), 32'd1);
        checkOutput("wren.rx_ready", 32'(d0RxReady), 32'd0);
        checkOutput("wren.err", 32'(d0Err), 32'd0);

        doReset();
        sendByte(8'h03); sendByte(8'h12); sendByte(8'h34); sendByte(8'h56);
        settle();
        checkOutput("read.pulses", 32'(cmdPulses0), 32'd1);
        checkOutput("read.addr", 32'(d0CmdAddr), 32'h123456);
        checkOutput("read.wr_pulses", 32'(wrPulses0), 32'd0);
        checkOutput("read.rx_done", 32'(d0RxDone), 32'd1);

        doReset();
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h01); sendByte(8'h00);
        sendByte(8'hA5); sendByte(8'h5A);
        settle();
        checkOutput("prog.addr", 32'(d0CmdAddr), 32'h000100);
        checkOutput("prog.wr_pulses", 32'(wrPulses0), 32'd2);
        checkOutput("prog.wr_data", 32'(d0WrData), 32'h5A);
        checkOutput("prog.wr_count", 32'(d0WrCount), 32'd2);
        checkOutput("prog.rx_ready", 32'(d0RxReady), 32'd1);
        checkOutput("prog2.rx_done", 32'(d1RxDone), 32'd1);
        sendByte(8'h77);
        settle();
        checkOutput("prog.wr_count3", 32'(d0WrCount), 32'd3);
        checkOutput("prog2.wr_count", 32'(d1WrCount), 32'd2);
        checkOutput("prog2.wr_pulses", 32'(wrPulses1), 32'd2);
        checkOutput("prog2.wr_data", 32'(d1WrData), 32'h5A);

        doReset();
        sendByte(8'hFF); sendByte(8'h03); sendByte(8'h12);
        settle();
        checkOutput("bad.err", 32'(d0Err), 32'd1);
        checkOutput("bad.rx_done", 32'(d0RxDone), 32'd1);
        checkOutput("bad.pulses", 32'(cmdPulses0), 32'd0);
        checkOutput("bad.cmd_op", 32'(d0CmdOp), 32'hFF);

        doReset();
        sendByte(8'h03); sendByte(8'h12);
        applyStimulus(4'h3, 1);
        doReset();
        settle();
        checkOutput("abort.cmd_op", 32'(d0CmdOp), 32'h00);
        checkOutput("abort.addr", 32'(d0CmdAddr), 32'h0);
        sendByte(8'h05);
        settle();
        checkOutput("abort.rdsr", 32'(d0CmdOp), 32'h05);
        checkOutput("abort.rx_done", 32'(d0RxDone), 32'd1);

        doReset();
        applyStimulus(4'h2, 3);
        applyStimulus(4'h0, 3);
        settle();
        checkOutput("hold.cmd_op", 32'(d0CmdOp), 32'h20);
        checkOutput("hold.rx_ready", 32'(d0RxReady), 32'd1);
        checkOutput("hold.pulses", 32'(cmdPulses0), 32'd0);

        @(negedge sck);
        ss = 1'b1;
        nibValid = 1'b1;
        nib = 4'h9;
        @(negedge sck);
        ss = 1'b0;
        nibValid = 1'b0;
        @(negedge sck);
        sendByte(8'h05);
        settle();
        checkOutput("race.cmd_op", 32'(d0CmdOp), 32'h05);
        checkOutput("race.rx_done", 32'(d0RxDone), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_cmd_assembler.md
# flash_cmd_assembler

Consumes the 4-bit nibble stream produced by the SPI serial-to-parallel receive stage, pairs nibbles into bytes (high nibble first), and parses each chip-select transaction into a flash command: opcode, optional address, optional program-data bytes. It drives the receive stage's `ready`/`done` controls and presents decoded commands and write data to the flash controller core.

## Interface
- `ADDR_BYTES`, default 3: address bytes following an addressed opcode, MSB first.
- `MAX_WR`, default 256: maximum program-data bytes per transaction (1..256).

- `sck`  in  1  clock; all state changes on its rising edge.
- `ss`  in  1  reset; synchronous, active-high (SPI deselected = reset).
- `nib_valid`  in  1  nibble-available strobe from the receive stage (its `pulse`).
- `nib`  in  4  nibble data (receive stage `parallel_out`).
- `rx_ready`  out  1  to receive stage `ready`: high in OPCODE/ADDR/DATA.
- `rx_done`  out  1  to receive stage `done`: high in DONE/ERROR.
- `cmd_valid`  out  1  one-cycle strobe: command header complete.
- `cmd_op`  out  8  latched opcode.
- `cmd_addr`  out  8*ADDR_BYTES  latched address.
- `wr_valid`  out  1  one-cycle strobe per program-data byte.
- `wr_data`  out  8  program-data byte, held until next byte.
- `wr_count`  out  9  program-data bytes accepted this transaction.
- `err`  out  1  sticky: unsupported opcode.

## Operation
- Nibble acceptance: rising edge of `nib_valid` only (high now, low on previous sampled edge); a held-high strobe counts once.
- Pairing: first accepted nibble → byte[7:4], second → byte[3:0]; byte completes on the second.
- Opcodes: 0x06 WREN, 0x05 RDSR (opcode only); 0x03 READ, 0x20 SECTOR_ERASE (opcode+address); 0x02 PROGRAM (opcode+address+data). Anything else is unsupported.
- OPCODE: byte → `cmd_op`. Opcode-only → `cmd_valid`, DONE. Addressed → ADDR, byte index 0. Unsupported → `err`=1, ERROR.
- ADDR: bytes shift into `cmd_addr` MSB first; on byte ADDR_BYTES → `cmd_valid`; PROGRAM → DATA, else DONE.
- DATA: each byte → `wr_data`, `wr_valid`, `wr_count`+1; the MAX_WR-th byte also moves to DONE.
- DONE/ERROR: terminal; nibbles ignored (edge history still tracked); exit only via `ss`.
- `rx_ready`/`rx_done` are combinational decodes of state; all other outputs registered.

## Timing
- Reset (`ss`=1 at an edge): state OPCODE, pairing cleared, `cmd_op`/`cmd_addr`/`wr_data`/`wr_count`/`err`/`cmd_valid`/`wr_valid`=0, edge history=0; hence `rx_ready`=1, `rx_done`=0 from the first cycle after reset.
- `ss` high with a nibble edge in the same cycle: reset wins, nibble dropped.
- Latency: `cmd_valid`/`wr_valid` assert in the cycle after the edge accepting the completing nibble; exactly one cycle wide; `cmd_op`/`cmd_addr` stable from that cycle until next reset.
- `cmd_valid` and first `wr_valid` never coincide (separate bytes).
- State transitions take effect at the same edge as the completing byte; `rx_done` rises with `cmd_valid` for terminal commands.
- Reset mid-transaction: partial byte, address, count discarded; no strobe emitted.
- No backpressure downstream: consumer must take `wr_data` on every `wr_valid` (≥8 `sck` between bytes by construction).

## Structure
- Package `flash_cmd_pkg`: opcode localparams, `state_t` enum (OPCODE, ADDR, DATA, DONE, ERROR), functions `op_has_addr`, `op_has_data`, `op_supported`.
- Sub-module `nibble_byte_packer`: `nib_valid` edge detect + hi/lo pairing, outputs `byte_valid`/`byte_data`; cleared by `ss`. Top holds FSM and output registers.

## Test plan
- Reset, nibbles 0,6 → `cmd_valid` one cycle, `cmd_op`=0x06, `rx_done`=1, `rx_ready`=0, `err`=0.
- READ: 0x03,0x12,0x34,0x56 → single `cmd_valid`, `cmd_addr`=0x123456, no `wr_valid`, DONE.
- PROGRAM: 0x02,0x00,0x01,0x00,0xA5,0x5A → `cmd_valid` with addr 0x000100, then `wr_valid` ×2 with 0xA5 (`wr_count`=1), 0x5A (`wr_count`=2); remains DATA; MAX_WR=2 build → DONE after 0x5A, further bytes ignored.
- Opcode 0xFF → `err`=1, `rx_done`=1, no `cmd_valid`; later nibbles change nothing.
- Bytes 0x03,0x12 plus one nibble, then `ss` high one cycle, then 0x05 → all outputs zero after reset, then `cmd_op`=0x05 decoded correctly (pairing cleared).
- `nib_valid` held high 3 cycles per nibble for byte 0x20 → one nibble per strobe, `cmd_op`=0x20, enters ADDR.
